copro_mailbox: RTL and testbench
================================

COPRO_MAILBOX -- requirements
Module: copro_mailbox

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, meaning log2 of host-to-6809 FIFO depth; legal range 1..3.
REQ-002 SHALL have port clock  input  1  single clock for all state; one clock, no other clock inputs.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port h_cs  input  1  host (C64 IO2) mailbox select, level, already synchronised to clock.
REQ-005 SHALL have port h_r_w  input  1  host access direction, 1 = read.
REQ-006 SHALL have port h_addr  input  1  host register select.
REQ-007 SHALL have port h_din  input  8  host write data.
REQ-008 SHALL have port h_dout  output  8  host read data, registered.
REQ-009 SHALL have ports c_cs, c_r_w, c_addr[0], c_din[7:0], c_dout[7:0] with the same meanings for the 6809 side.
REQ-010 SHALL have port _irq_09  output  1  6809 interrupt request, active-low, registered.

Function
REQ-011 SHALL detect an access event on each side in the first clock cycle where cs=1 and its registered previous value was 0; one event per cs assertion, regardless of assertion length.
REQ-012 SHALL commit all effects of an event at the clock edge ending the event cycle; status, FIFO state, h_dout/c_dout, and _irq_09 reflect the event one cycle after event detection.
REQ-013 SHALL hold h_dout and c_dout unchanged between read events; write events do not alter them.
REQ-014 Host write addr 0 SHALL push h_din into the FIFO; if the FIFO is full, data is dropped and sticky tx_ovf is set.
REQ-015 Host write addr 1 SHALL flush the FIFO when h_din[0]=1, setting count to 0; the write has no other effect.
REQ-016 Host read addr 0 SHALL load h_dout with the rx latch and clear rx_full.
REQ-017 Host read addr 1 SHALL load h_dout with {count[3:0], tx_ovf, rx_full, tx_empty, tx_full}, then clear tx_ovf; the read value contains the pre-clear flag.
REQ-018 6809 read addr 0 SHALL pop the FIFO head into c_dout; if the FIFO is empty, c_dout = 8'hFF and count is unchanged.
REQ-019 6809 write addr 0 SHALL load the rx latch with c_din and set rx_full; if rx_full was already 1, data is overwritten and sticky rx_ovf is set.
REQ-020 6809 read addr 1 SHALL load c_dout with {irq_en, 3'b0, rx_ovf, rx_full, tx_full, !tx_empty}, then clear rx_ovf.
REQ-021 6809 write addr 1 SHALL set irq_en = c_din[7]; other bits are ignored.
REQ-022 The FIFO SHALL be a circular buffer with read/write pointers of DEPTH_LOG2 bits that wrap modulo 2^DEPTH_LOG2, plus count of DEPTH_LOG2+1 bits; tx_full = (count == 2^DEPTH_LOG2), tx_empty = (count == 0).
REQ-023 On a same-cycle push and pop with FIFO non-empty, both SHALL occur and count stays unchanged; this includes the full case, where the push is accepted.
REQ-024 On a same-cycle push and pop with FIFO empty, the push SHALL be accepted, the pop returns 8'hFF, and there is no bypass.
REQ-025 On a same-cycle flush and pop/push, the flush SHALL dominate: count = 0, the push is discarded without setting tx_ovf, and the pop returns 8'hFF.
REQ-026 On a same-cycle host rx read and 6809 rx write, h_dout SHALL get the old latch value and rx_full ends at 1; rx_ovf is set only if rx_full was 1 before the cycle.
REQ-027 _irq_09 SHALL be registered as !(irq_en & !tx_empty), computed from post-commit state, and remain low until the FIFO drains or irq_en is cleared.
REQ-028 Host-side and 6809-side events in the same cycle SHALL both be serviced with no arbitration stall.

Reset
REQ-029 While reset=1 at a clock edge, SHALL set:
  - pointers, count, tx_ovf, rx_ovf, rx_full, irq_en: 0
  - rx latch, h_dout, c_dout: 8'h00
  - cs_prev registers: 0
  - _irq_09: 1
REQ-030 Reset mid-access SHALL abort the access with no effect; a cs still asserted when reset deasserts SHALL generate a new event on its first cycle out of reset.
REQ-031 FIFO storage contents need not be reset.

Verification
REQ-032 Reset, then host read addr 1 -> h_dout = 8'h02 (empty); 6809 read addr 0 -> c_dout = 8'hFF.
REQ-033 irq_en=1, host push 8'hA5, then 8'h5A -> _irq_09 low one cycle after first push; 6809 pops return A5, then 5A; _irq_09 high one cycle after second pop.
REQ-034 DEPTH_LOG2=3: push 9 bytes 00..08 -> status 8'h89 (count 8, tx_ovf, full); next status read 8'h81; pops return 00..07, then FF.
REQ-035 Full FIFO, host push 8'h77 in the same cycle as a 6809 pop -> pop returns oldest byte, count stays 8, 8'h77 emerges last, tx_ovf stays 0.
REQ-036 6809 writes 8'h11 then 8'h22 with no host read -> 6809 status bits[3:2] = 2'b11; host read addr 0 -> 8'h22, rx_full cleared.
REQ-037 Push 3 bytes, then host writes flush in the same cycle as a 6809 pop -> count 0, pop returns FF, _irq_09 high next cycle.

Source files
------------

// File: rtl/copro_mailbox.sv
// copro_mailbox
//   Byte mailbox between a host (C64 IO2 window) and a 6809 coprocessor.
//   Host -> 6809 traffic goes through a small circular FIFO; 6809 -> host
//   traffic goes through a single rx latch. Each side raises one access
//   event on the rising edge of its (already synchronised) chip select, and
//   every effect of that event is committed at the end of the event cycle.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   h_cs/h_r_w/h_addr     host select (level), direction (1=read), reg select
//   h_din / h_dout        host write data / registered host read data
//   c_cs/c_r_w/c_addr     6809 select, direction, reg select
//   c_din / c_dout        6809 write data / registered 6809 read data
//   _irq_09               6809 interrupt, active low, registered
//
// Register map
//   host  wr 0: push FIFO          host  rd 0: rx latch (clears rx_full)
//   host  wr 1: bit0=1 flush FIFO  host  rd 1: {count[3:0],tx_ovf,rx_full,
//                                                tx_empty,tx_full}
//   6809  wr 0: load rx latch      6809  rd 0: pop FIFO (FF when empty)
//   6809  wr 1: irq_en = din[7]    6809  rd 1: {irq_en,000,rx_ovf,rx_full,
//                                                tx_full,!tx_empty}
module copro_mailbox #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       h_cs,
  input  logic       h_r_w,
  input  logic       h_addr,
  input  logic [7:0] h_din,
  output logic [7:0] h_dout,
  input  logic       c_cs,
  input  logic       c_r_w,
  input  logic       c_addr,
  input  logic [7:0] c_din,
  output logic [7:0] c_dout,
  output logic       _irq_09
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd, r_wr;
  logic [CW-1:0]         r_count;
  logic                  r_tx_ovf, r_rx_ovf, r_rx_full, r_irq_en;
  logic [7:0]            r_rx, r_h_dout, r_c_dout;
  logic                  r_irq_n;
  logic                  r_h_cs_prev, r_c_cs_prev;

  // Event detect: first cycle of each cs assertion
  logic w_h_ev, w_c_ev;
  assign w_h_ev = h_cs & ~r_h_cs_prev;
  assign w_c_ev = c_cs & ~r_c_cs_prev;

  // Access decode
  logic w_h_push, w_h_flush, w_h_rrx, w_h_rst;
  logic w_c_pop, w_c_wrx, w_c_rst, w_c_wie;
  assign w_h_push  = w_h_ev & ~h_r_w & ~h_addr;
  assign w_h_flush = w_h_ev & ~h_r_w &  h_addr & h_din[0];
  assign w_h_rrx   = w_h_ev &  h_r_w & ~h_addr;
  assign w_h_rst   = w_h_ev &  h_r_w &  h_addr;
  assign w_c_pop   = w_c_ev &  c_r_w & ~c_addr;
  assign w_c_wrx   = w_c_ev & ~c_r_w & ~c_addr;
  assign w_c_rst   = w_c_ev &  c_r_w &  c_addr;
  assign w_c_wie   = w_c_ev & ~c_r_w &  c_addr;

  logic w_tx_empty, w_tx_full;
  assign w_tx_empty = (r_count == '0);
  assign w_tx_full  = (r_count == FULL_CNT);

  // Flush dominates both FIFO ports. A pop on a full FIFO frees the slot the
  // same-cycle push lands in; a pop on an empty FIFO never sees that push.
  logic          w_pop_ok, w_push_ok, w_tx_ovf_set, w_irq_en_nxt;
  logic [CW-1:0] w_count_nxt;
  always_comb begin
    w_pop_ok     = w_c_pop & ~w_tx_empty & ~w_h_flush;
    w_push_ok    = w_h_push & ~w_h_flush & (~w_tx_full | w_pop_ok);
    w_tx_ovf_set = w_h_push & ~w_h_flush & w_tx_full & ~w_pop_ok;
    w_count_nxt  = r_count;
    if (w_h_flush)
      w_count_nxt = '0;
    else if (w_push_ok & ~w_pop_ok)
      w_count_nxt = r_count + CW'(1);
    else if (w_pop_ok & ~w_push_ok)
      w_count_nxt = r_count - CW'(1);
    w_irq_en_nxt = w_c_wie ? c_din[7] : r_irq_en;
  end

  // Status words sample pre-event state
  logic [7:0] w_h_stat, w_c_stat;
  assign w_h_stat = {4'(r_count), r_tx_ovf, r_rx_full, w_tx_empty, w_tx_full};
  assign w_c_stat = {r_irq_en, 3'b000, r_rx_ovf, r_rx_full, w_tx_full, ~w_tx_empty};

  // FIFO storage is not reset; pointers/count define validity
  always_ff @(posedge clock) begin
    if (!reset && w_push_ok)
      r_mem[r_wr] <= h_din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd        <= '0;
      r_wr        <= '0;
      r_count     <= '0;
      r_tx_ovf    <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_rx_full   <= 1'b0;
      r_irq_en    <= 1'b0;
      r_rx        <= 8'h00;
      r_h_dout    <= 8'h00;
      r_c_dout    <= 8'h00;
      r_irq_n     <= 1'b1;
      r_h_cs_prev <= 1'b0;
      r_c_cs_prev <= 1'b0;
    end else begin
      r_h_cs_prev <= h_cs;
      r_c_cs_prev <= c_cs;

      if (w_h_flush) begin
        r_rd <= '0;
        r_wr <= '0;
      end else begin
        if (w_push_ok) r_wr <= r_wr + DEPTH_LOG2'(1);
        if (w_pop_ok)  r_rd <= r_rd + DEPTH_LOG2'(1);
      end
      r_count  <= w_count_nxt;
      r_tx_ovf <= (r_tx_ovf & ~w_h_rst) | w_tx_ovf_set;

      if (w_h_rrx)      r_h_dout <= r_rx;
      else if (w_h_rst) r_h_dout <= w_h_stat;

      if (w_c_pop)      r_c_dout <= w_pop_ok ? r_mem[r_rd] : 8'hFF;
      else if (w_c_rst) r_c_dout <= w_c_stat;

      // A 6809 write in the same cycle as a host rx read wins rx_full; the
      // host still gets the old latch value above.
      if (w_c_wrx) r_rx <= c_din;
      r_rx_full <= w_c_wrx | (r_rx_full & ~w_h_rrx);
      r_rx_ovf  <= (r_rx_ovf & ~w_c_rst) | (w_c_wrx & r_rx_full);

      r_irq_en <= w_irq_en_nxt;
      r_irq_n  <= ~(w_irq_en_nxt & (w_count_nxt != '0));
    end
  end

  assign h_dout  = r_h_dout;
  assign c_dout  = r_c_dout;
  assign _irq_09 = r_irq_n;

endmodule

// File: tb/tb_copro_mailbox.sv
// tb_copro_mailbox
//   Directed steps followed by randomized traffic, all compared against a
//   queue-based mailbox model kept here. Outputs are sampled 1 time unit
//   after the rising edge; inputs change on the falling edge.
module tb_copro_mailbox;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       h_cs = 1'b0, h_r_w = 1'b0, h_addr = 1'b0;
  logic [7:0] h_din = 8'h00;
  logic [7:0] h_dout;
  logic       c_cs = 1'b0, c_r_w = 1'b0, c_addr = 1'b0;
  logic [7:0] c_din = 8'h00;
  logic [7:0] c_dout;
  logic       _irq_09;

  copro_mailbox #(.DEPTH_LOG2(DL)) dut (
    .clock(clock), .reset(reset),
    .h_cs(h_cs), .h_r_w(h_r_w), .h_addr(h_addr), .h_din(h_din), .h_dout(h_dout),
    .c_cs(c_cs), .c_r_w(c_r_w), .c_addr(c_addr), .c_din(c_din), .c_dout(c_dout),
    ._irq_09(_irq_09)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model
  logic [7:0] mq[$];
  logic       m_txovf, m_rxfull, m_rxovf, m_irqen;
  logic [7:0] m_rx, m_hd, m_cd;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_txovf = 0; m_rxfull = 0; m_rxovf = 0; m_irqen = 0;
    m_rx = 8'h00; m_hd = 8'h00; m_cd = 8'h00;
  endtask

  task automatic model_step(input logic hv, hrw, ha, input logic [7:0] hd,
                            input logic cv, crw, ca, input logic [7:0] cd);
    int   sz;
    logic push, flush, pop, old_full;
    sz       = mq.size();
    push     = hv & !hrw & !ha;
    flush    = hv & !hrw & ha & hd[0];
    pop      = cv & crw & !ca;
    old_full = m_rxfull;
    // register reads see the state before this cycle
    if (hv && hrw && !ha) m_hd = m_rx;
    if (hv && hrw && ha) begin
      m_hd = {4'(sz), m_txovf, m_rxfull, sz == 0, sz == DEPTH};
      m_txovf = 0;
    end
    if (cv && crw && ca) begin
      m_cd = {m_irqen, 3'b000, m_rxovf, m_rxfull, sz == DEPTH, sz != 0};
      m_rxovf = 0;
    end
    if (hv && hrw && !ha) m_rxfull = 0;
    if (cv && !crw && !ca) begin
      if (old_full) m_rxovf = 1;
      m_rx = cd;
      m_rxfull = 1;
    end
    if (cv && !crw && ca) m_irqen = cd[7];
    // FIFO
    if (flush) begin
      mq.delete();
      if (pop) m_cd = 8'hFF;
    end else begin
      if (pop) m_cd = (sz > 0) ? mq.pop_front() : 8'hFF;
      if (push) begin
        if (sz < DEPTH || (pop && sz > 0)) mq.push_back(hd);
        else m_txovf = 1;
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "/h_dout"}, h_dout, m_hd);
    chk({tag, "/c_dout"}, c_dout, m_cd);
    chk({tag, "/irq"}, {7'b0, _irq_09}, {7'b0, !(m_irqen && mq.size() != 0)});
  endtask

  // One access (either or both sides), cs held 'hold' cycles, then one idle
  task automatic cyc(input logic hv, hrw, ha, input logic [7:0] hd,
                     input logic cv, crw, ca, input logic [7:0] cd,
                     input int hold, input string tag);
    @(negedge clock);
    h_cs = hv; h_r_w = hrw; h_addr = ha; h_din = hd;
    c_cs = cv; c_r_w = crw; c_addr = ca; c_din = cd;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (i == 0) model_step(hv, hrw, ha, hd, cv, crw, ca, cd);
      chk_all(tag);
    end
    @(negedge clock);
    h_cs = 0; c_cs = 0;
    @(posedge clock); #1;
    chk_all(tag);
  endtask

  task automatic hw(input logic a, input logic [7:0] d, input string t);
    cyc(1, 0, a, d, 0, 0, 0, 8'h00, 1, t);
  endtask
  task automatic hr(input logic a, input string t);
    cyc(1, 1, a, 8'h00, 0, 0, 0, 8'h00, 1, t);
  endtask
  task automatic cw(input logic a, input logic [7:0] d, input string t);
    cyc(0, 0, 0, 8'h00, 1, 0, a, d, 1, t);
  endtask
  task automatic cr(input logic a, input string t);
    cyc(0, 0, 0, 8'h00, 1, 1, a, 8'h00, 1, t);
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst/h_dout", h_dout, 8'h00);
    chk("rst/c_dout", c_dout, 8'h00);
    chk("rst/irq", {7'b0, _irq_09}, 8'h01);
    @(negedge clock); reset = 0;

    // Empty status and empty pop
    hr(1, "empty_stat");  chk("empty_stat_k", h_dout, 8'h02);
    cr(0, "empty_pop");   chk("empty_pop_k", c_dout, 8'hFF);

    // Interrupt follows FIFO occupancy
    cw(1, 8'h80, "irq_en");
    chk("irq_en_idle", {7'b0, _irq_09}, 8'h01);
    hw(0, 8'hA5, "push_a5");  chk("irq_low", {7'b0, _irq_09}, 8'h00);
    hw(0, 8'h5A, "push_5a");
    cr(0, "pop_a5");          chk("pop_a5_k", c_dout, 8'hA5);
    chk("irq_still_low", {7'b0, _irq_09}, 8'h00);
    cr(0, "pop_5a");          chk("pop_5a_k", c_dout, 8'h5A);
    chk("irq_high", {7'b0, _irq_09}, 8'h01);

    // Overflow on the ninth push
    for (int i = 0; i < 9; i++) hw(0, 8'(i), "fill9");
    hr(1, "ovf_stat");    chk("ovf_stat_k", h_dout, 8'h89);
    hr(1, "ovf_clr");     chk("ovf_clr_k", h_dout, 8'h81);
    for (int i = 0; i < 8; i++) begin
      cr(0, "drain");     chk("drain_k", c_dout, 8'(i));
    end
    cr(0, "drain_empty"); chk("drain_empty_k", c_dout, 8'hFF);

    // Push into a full FIFO while popping
    for (int i = 0; i < 8; i++) hw(0, 8'h10 + 8'(i), "fill8");
    cyc(1, 0, 0, 8'h77, 1, 1, 0, 8'h00, 1, "full_pp");
    chk("full_pp_k", c_dout, 8'h10);
    hr(1, "full_pp_stat"); chk("full_pp_stat_k", h_dout, 8'h81);
    for (int i = 1; i < 8; i++) cr(0, "full_pp_drain");
    cr(0, "last77");      chk("last77_k", c_dout, 8'h77);

    // rx latch overwrite
    cw(0, 8'h11, "rx11");
    cw(0, 8'h22, "rx22");
    cr(1, "rx_stat");     chk("rx_stat_k", c_dout, 8'h8C);
    hr(0, "rx_read");     chk("rx_read_k", h_dout, 8'h22);
    cr(1, "rx_stat2");    chk("rx_stat2_k", c_dout, 8'h80);

    // Flush against a pop
    hw(0, 8'h01, "p1"); hw(0, 8'h02, "p2"); hw(0, 8'h03, "p3");
    cyc(1, 0, 1, 8'h01, 1, 1, 0, 8'h00, 1, "flush_pop");
    chk("flush_pop_k", c_dout, 8'hFF);
    chk("flush_irq", {7'b0, _irq_09}, 8'h01);
    hr(1, "flush_stat");  chk("flush_stat_k", h_dout, 8'h02);

    // Host rx read against 6809 rx write
    cw(0, 8'h33, "rx33");
    cyc(1, 1, 0, 8'h00, 1, 0, 0, 8'h44, 1, "rx_race");
    chk("rx_race_k", h_dout, 8'h33);
    cr(1, "rx_race_stat"); chk("rx_race_stat_k", c_dout, 8'h8C);

    // Push and pop on an empty FIFO: no bypass
    cyc(1, 0, 0, 8'h99, 1, 1, 0, 8'h00, 1, "empty_pp");
    chk("empty_pp_k", c_dout, 8'hFF);
    cr(0, "empty_pp_pop"); chk("empty_pp_pop_k", c_dout, 8'h99);

    // Long cs assertion produces one event
    cyc(1, 0, 0, 8'hAB, 0, 0, 0, 8'h00, 3, "long_cs");
    cr(0, "long_pop1");   chk("long_pop1_k", c_dout, 8'hAB);
    cr(0, "long_pop2");   chk("long_pop2_k", c_dout, 8'hFF);

    // Reset mid-access: aborted, then a fresh event once reset drops
    @(negedge clock);
    reset = 1; h_cs = 1; h_r_w = 0; h_addr = 0; h_din = 8'hCD;
    @(posedge clock); #1;
    model_reset();
    chk_all("rst_mid");
    @(negedge clock); reset = 0;
    @(posedge clock); #1;
    model_step(1, 0, 0, 8'hCD, 0, 0, 0, 8'h00);
    chk_all("rst_exit");
    @(negedge clock); h_cs = 0;
    @(posedge clock); #1;
    cr(0, "rst_pop");     chk("rst_pop_k", c_dout, 8'hCD);

    // Randomized traffic on both sides
    for (int n = 0; n < 400; n++) begin
      logic hv, hrw, ha, cv, crw, ca;
      logic [7:0] hd, cd;
      hv  = ($urandom_range(0, 3) != 0);
      hrw = $urandom_range(0, 1);
      ha  = ($urandom_range(0, 3) == 0);
      hd  = 8'($urandom);
      cv  = ($urandom_range(0, 2) != 0);
      crw = $urandom_range(0, 1);
      ca  = $urandom_range(0, 1);
      cd  = 8'($urandom);
      cyc(hv, hrw, ha, hd, cv, crw, ca, cd, int'($urandom_range(1, 2)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
